// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// IMEM_LOADER_CSUM_EN adds the trailing-checksum state to the loader FSM.
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         LEN_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
`ifdef IMEM_LOADER_CSUM_EN
    ST_CSUM,
`endif
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/imem_boot_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle
// rx_valid / rx_ferr strobes at the stop-bit sample.
module uart_rx
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic          sync1_q, sync2_q, prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        // Only a true high-to-low transition starts a byte, so a line held
        // low after a framing error does not retrigger.
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign rx_data  = shift_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/imem_boot_loader.sv
// UART boot loader: writes a framed program image into instruction memory and
// holds the core in reset until done. IMEM_LOADER_CSUM_EN enables the checksum.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        load_err,
  output logic [15:0] words_loaded
);

  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;
`ifdef IMEM_LOADER_CSUM_EN
  localparam state_e AFTER_DATA = ST_CSUM;
`else
  localparam state_e AFTER_DATA = ST_DONE;
`endif

  logic [7:0]       rx_data;
  logic             rx_valid, rx_ferr;
  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, len_rx;
  logic [LEN_W-1:0] words_q, words_d;
  logic [23:0]      asm_q, asm_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic             run_q, run_d, err_q, err_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  assign len_rx = {rx_data, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    words_d = words_q;
    asm_d   = asm_q;
    bcnt_d  = bcnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    run_d   = run_q;
    err_d   = err_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = ST_LEN_LO;
          err_d   = 1'b0;
          words_d = '0;
        end
      end
      ST_LEN_LO: begin
        if (rx_valid) begin
          len_d   = {8'h00, rx_data};
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (rx_valid) begin
          len_d  = len_rx;
          bcnt_d = 2'd0;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d = 8'h00;
`endif
          if (32'(len_rx) > MAX_WORDS) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (len_rx == '0) begin
            state_d = AFTER_DATA;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          asm_d  = {rx_data, asm_q[23:8]};
          bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = {14'd0, words_q, 2'b00};
            wdata_d = {rx_data, asm_q};
            words_d = words_q + 16'd1;
            if (words_q + 16'd1 == len_q) state_d = AFTER_DATA;
          end
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      ST_CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            state_d = ST_DONE;
            run_d   = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
`endif
      ST_DONE: begin
        run_d = 1'b1;
        // Reload drops the core back into reset on the same edge as LEN_LO.
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = ST_LEN_LO;
          run_d   = 1'b0;
          err_d   = 1'b0;
          words_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rx_ferr && state_q != ST_IDLE && state_q != ST_DONE) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      words_q <= '0;
      bcnt_q  <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      bcnt_q  <= bcnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    len_q  <= len_d;
    asm_q  <= asm_d;
`ifdef IMEM_LOADER_CSUM_EN
    csum_q <= csum_d;
`endif
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_rst_n    = run_q;
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign load_err     = err_q;
  assign words_loaded = words_q;

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

UART boot loader that sits directly upstream of the single-cycle CPU core. It receives a framed program image over a serial line and writes it word by word into instruction memory through a dedicated write port. It holds the core in reset until the image is loaded, then releases it.

## Interface
Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- ADDR_W, 8: instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial input, 8N1, idle high; asynchronous to clk.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  32  byte address of the write, word-aligned (word_index << 2).
- imem_wdata  out  32  instruction word to write.
- cpu_rst_n  out  1  drives the core's rst_n; 0 holds the core in reset.
- busy  out  1  a load is in progress.
- load_err  out  1  sticky error flag for the last load attempt.
- words_loaded  out  16  number of words written in the current or last load.

## Operation
- Frame format: sync byte 0xA5, then LEN_LO, then LEN_HI (word count N, little-endian), then 4·N data bytes (each word little-endian), then one checksum byte (present only with the macro).
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE.
- IDLE: non-0xA5 bytes are ignored. 0xA5 moves to LEN_LO and clears load_err and words_loaded.
- LEN_HI: after it is received, N > 2^ADDR_W sets load_err and returns to IDLE; no writes are made. N == 0 goes to CSUM (macro on) or DONE (macro off).
- DATA: bytes are shifted into a 32-bit assembler. On every 4th byte:
  - imem_we pulses with imem_addr = words_loaded·4 and the assembled word on imem_wdata;
  - words_loaded increments.
  - After word N, go to CSUM or DONE.
- DONE: cpu_rst_n = 1. Bytes other than 0xA5 are ignored. 0xA5 starts a reload: cpu_rst_n drops to 0 in the same cycle the FSM enters LEN_LO.
- Framing error (stop bit sampled 0) in any state other than IDLE or DONE:
  - the byte is discarded;
  - load_err = 1, FSM returns to IDLE, cpu_rst_n stays 0.
  - In IDLE or DONE the bad byte is only dropped.
- Words already written before an abort stay in memory. No rollback.
- busy = 1 in LEN_LO, LEN_HI, DATA and CSUM.
- UART receiver:
  - uart_rx passes through a 2-flop synchronizer.
  - A falling edge in receiver idle starts a byte. The start bit is re-checked at CLKS_PER_BIT/2; if it is high, the byte is treated as a glitch and dropped.
  - Data bits are sampled every CLKS_PER_BIT after that, LSB first.
  - At the stop-bit sample the receiver emits a one-cycle rx_valid or rx_ferr.

## Timing
- Reset values: imem_we 0, imem_addr 0, imem_wdata 0, cpu_rst_n 0, busy 0, load_err 0, words_loaded 0. The FSM and receiver return to idle asynchronously.
- rst_n asserted mid-load aborts immediately. Memory contents are not touched.
- Byte-to-FSM latency: rx_valid is asserted 2 synchronizer cycles plus 9.5·CLKS_PER_BIT (±1) cycles after the start-bit falling edge.
- imem_we is registered: it is high in the cycle after rx_valid of the 4th byte of a word. It is never high on two consecutive cycles.
- cpu_rst_n rises in the cycle after the final imem_we (macro off) or after rx_valid of the checksum byte (macro on).
- load_err and state updates take effect in the cycle after the triggering rx_valid or rx_ferr.

## Configuration
- IMEM_LOADER_CSUM_EN defined:
  - The CSUM state exists and the frame carries a trailing checksum byte.
  - Checksum = XOR of all 4·N data bytes.
  - Match: go to DONE.
  - Mismatch: load_err = 1, go to IDLE, cpu_rst_n stays 0.
- Undefined: there is no CSUM state and no checksum byte. The FSM goes from the last data word (or N == 0) straight to DONE.

## Structure
- Package imem_loader_pkg holds:
  - the state enum typedef;
  - SYNC_BYTE = 8'hA5;
  - the LEN field width (16).
- Sub-module uart_rx (synchronizer, bit-timing counter, shift register; outputs rx_data[7:0], rx_valid, rx_ferr), instantiated once.

## Test plan
CLKS_PER_BIT = 16, ADDR_W = 8, macro defined unless stated.
- Reset, then bytes 0x00, 0xFF -> all outputs stay at reset values, busy = 0, no imem_we.
- Frame A5 02 00 13 05 10 00 93 05 20 00 B0 -> imem_we at addr 0x0 with data 0x00100513, then at addr 0x4 with 0x00200593; words_loaded = 2; cpu_rst_n = 1; load_err = 0. With the macro undefined, the same frame without B0 gives the same result.
- Same frame with checksum 0xB1 -> both writes occur, load_err = 1, cpu_rst_n = 0, busy = 0.
- A5 01 01 (N = 257) -> load_err = 1 after LEN_HI, no imem_we, FSM in IDLE.
- Stop bit driven 0 on the 3rd data byte -> no imem_we, load_err = 1. A following valid frame loads correctly and clears load_err.
- Two error cases:
  - rst_n pulsed low mid-DATA -> outputs reset asynchronously, and a fresh frame then succeeds.
  - 0xA5 received in DONE -> cpu_rst_n falls the next cycle and a reload proceeds.
